// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
`timescale 1ns/1ps
package mem_arb_pkg;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2_f(input int value);
        int res;
        res = 32'sd0;
        for (int b = 32'sd0; b < 32'sd31; b++) begin
            if ((32'sd1 << b) < value) begin
                res = b + 32'sd1;
            end
        end
        return res;
    endfunction

    localparam int DEF_BURST      = 32'sd4;
    localparam int DEF_STARVE_MAX = 32'sd8;
    localparam int BEAT_W         = clog2_f(DEF_BURST);
    localparam int STARVE_W       = clog2_f(DEF_STARVE_MAX + 32'sd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST_D = 2'd1,
        ST_BURST_I = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_beat_ctr.sv
// Issued/returned beat counters for the currently granted burst.
`timescale 1ns/1ps
module mem_arb_beat_ctr #(
    parameter int BURST = 32'sd4,
    parameter int CNT_W = 32'sd3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             issue_inc,
    input  logic             return_inc,
    output logic [CNT_W-1:0] issued,
    output logic [CNT_W-1:0] returned,
    output logic             issue_last,
    output logic             issue_full,
    output logic             return_last
);

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BURST - 32'sd1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(32'sd1);

    logic [CNT_W-1:0] issued_r;
    logic [CNT_W-1:0] returned_r;

    // Beats accepted by memory in this burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_r <= '0;
        end else if (clr) begin
            issued_r <= '0;
        end else if (issue_inc) begin
            issued_r <= issued_r + ONE_C;
        end else begin
            issued_r <= issued_r;
        end
    end

    // Read words returned by memory in this burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            returned_r <= '0;
        end else if (clr) begin
            returned_r <= '0;
        end else if (return_inc) begin
            returned_r <= returned_r + ONE_C;
        end else begin
            returned_r <= returned_r;
        end
    end

    assign issued      = issued_r;
    assign returned    = returned_r;
    assign issue_last  = (issued_r == LAST_C);
    assign issue_full  = (issued_r == BURST_C);
    assign return_last = (returned_r == LAST_C);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates unified main memory between D-cache (priority) and I-cache
// line bursts, with a starvation counter guaranteeing I-cache progress.
`timescale 1ns/1ps
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST      = DEF_BURST,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic        d_rvalid,
    output logic        d_done,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic        i_rvalid,
    output logic        i_done,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_stall,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        err
);

    localparam int BEAT_BITS   = clog2_f(BURST);
    localparam int CNT_BITS    = BEAT_BITS + 32'sd1;
    localparam int STARVE_BITS = clog2_f(STARVE_MAX + 32'sd1);
    localparam logic [STARVE_BITS-1:0] STARVE_C = STARVE_BITS'(STARVE_MAX);
    localparam logic [STARVE_BITS-1:0] STARVE_ONE = STARVE_BITS'(32'sd1);

    arb_state_e state_r;
    arb_state_e state_nxt_s;

    logic [STARVE_BITS-1:0] starve_r;
    logic                   err_r;

    logic [CNT_BITS-1:0] issued_s;
    logic [CNT_BITS-1:0] returned_s;
    logic                issue_last_s;
    logic                issue_full_s;
    logic                return_last_s;

    logic        in_burst_s;
    logic        burst_wr_s;
    logic        mem_en_s;
    logic        issue_s;
    logic        rv_read_s;
    logic        rv_ok_s;
    logic        err_set_s;
    logic        burst_done_s;
    logic        starve_full_s;
    logic        enter_i_s;
    logic [15:0] base_s;
    logic [15:0] addr_s;
    logic        unused_addr_s;

    mem_arb_beat_ctr #(
        .BURST (BURST),
        .CNT_W (CNT_BITS)
    ) u_beat_ctr (
        .clk         (clk),
        .rst         (rst),
        .clr         (state_r == ST_IDLE),
        .issue_inc   (issue_s),
        .return_inc  (rv_ok_s),
        .issued      (issued_s),
        .returned    (returned_s),
        .issue_last  (issue_last_s),
        .issue_full  (issue_full_s),
        .return_last (return_last_s)
    );

    assign in_burst_s    = (state_r != ST_IDLE);
    assign burst_wr_s    = (state_r == ST_BURST_D) & d_wr;
    assign mem_en_s      = in_burst_s & ~issue_full_s;
    assign issue_s       = mem_en_s & ~mem_stall;
    assign rv_read_s     = mem_rvalid & in_burst_s & ~burst_wr_s;
    // A read return is only legitimate while a beat is outstanding.
    assign rv_ok_s       = rv_read_s & (returned_s != issued_s);
    assign err_set_s     = mem_rvalid & in_burst_s & (burst_wr_s | (returned_s == issued_s));
    // Writes finish on the last accepted beat, reads on the last returned word.
    assign burst_done_s  = burst_wr_s ? (issue_s & issue_last_s) : (rv_ok_s & return_last_s);
    assign starve_full_s = (starve_r == STARVE_C);
    assign enter_i_s     = (state_r == ST_IDLE) & (state_nxt_s == ST_BURST_I);

    assign base_s        = (state_r == ST_BURST_I) ? i_addr : d_addr;
    assign addr_s        = {base_s[15:BEAT_BITS+1], issued_s[BEAT_BITS-1:0], 1'b0};
    assign unused_addr_s = ^base_s[BEAT_BITS:0];

    assign rdata     = mem_rdata;
    assign mem_wdata = d_wdata;
    assign err       = err_r;

    // State register; reset abandons any in-flight burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant decision in IDLE, return to IDLE when the burst completes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_req && starve_full_s) begin
                    state_nxt_s = ST_BURST_I;
                end else if (d_req) begin
                    state_nxt_s = ST_BURST_D;
                end else if (i_req) begin
                    state_nxt_s = ST_BURST_I;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST_D, ST_BURST_I: begin
                if (burst_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Route memory handshakes to the granted side only.
    always_comb begin
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = 16'h0000;
        d_ack    = 1'b0;
        d_rvalid = 1'b0;
        d_done   = 1'b0;
        i_ack    = 1'b0;
        i_rvalid = 1'b0;
        i_done   = 1'b0;
        case (state_r)
            ST_BURST_D: begin
                mem_en   = mem_en_s;
                mem_wr   = d_wr;
                mem_addr = addr_s;
                d_ack    = issue_s;
                d_rvalid = rv_read_s;
                d_done   = burst_done_s;
            end
            ST_BURST_I: begin
                mem_en   = mem_en_s;
                mem_wr   = 1'b0;
                mem_addr = addr_s;
                i_ack    = issue_s;
                i_rvalid = rv_read_s;
                i_done   = burst_done_s;
            end
            default: begin
                mem_en   = 1'b0;
            end
        endcase
    end

    // Cycles an I request has waited; saturates so I eventually wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_r <= '0;
        end else if (enter_i_s) begin
            starve_r <= '0;
        end else if (i_req && (state_r != ST_BURST_I) && !starve_full_s) begin
            starve_r <= starve_r + STARVE_ONE;
        end else begin
            starve_r <= starve_r;
        end
    end

    // Sticky protocol error on unexpected read returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 2-cycle-latency memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] d_addr = 16'h0000, d_wdata = 16'h0000;
    logic        d_ack, d_rvalid, d_done;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = 16'h0000;
    logic        i_ack, i_rvalid, i_done;
    logic [15:0] rdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_stall = 1'b0;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        err;

    logic        inj_rv = 1'b0;
    logic        rv_p0 = 1'b0, rv_p1 = 1'b0;
    logic [15:0] rd_p0 = 16'h0000, rd_p1 = 16'h0000;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_done(d_done),
        .i_req(i_req), .i_addr(i_addr),
        .i_ack(i_ack), .i_rvalid(i_rvalid), .i_done(i_done),
        .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_stall(mem_stall),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    // Memory model: each accepted read returns addr^5A5A two cycles later.
    always @(posedge clk) begin
        rv_p1 <= rv_p0;
        rd_p1 <= rd_p0;
        rv_p0 <= mem_en & ~mem_stall & ~mem_wr;
        rd_p0 <= mem_addr ^ 16'h5A5A;
    end
    assign mem_rvalid = rv_p1 | inj_rv;
    assign mem_rdata  = rd_p1;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; d_req = 1'b0; d_wr = 1'b0; i_req = 1'b0;
        mem_stall = 1'b0; inj_rv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({mem_en, d_ack, d_rvalid, d_done, i_ack, i_rvalid, i_done, err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {mem_en, d_ack, d_rvalid, d_done, i_ack, i_rvalid, i_done, err});
        end
        checks++;
        if (mem_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_addr: got %h required 0000", mem_addr);
        end
        do_reset();
        #1;
        checks++;
        if (rdata !== mem_rdata) begin
            errors++; $display("FAIL rdata_passthru: got %h required %h", rdata, mem_rdata);
        end
    endtask

    task automatic test_single_read();
        logic [15:0] exp_addr [4];
        int acks, rvs;
        bit done_seen;
        exp_addr = '{16'h0100, 16'h0102, 16'h0104, 16'h0106};
        acks = 0; rvs = 0; done_seen = 1'b0;
        do_reset();
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0104;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            @(negedge clk); #1;
            checks++;
            if ({i_ack, i_rvalid, i_done} !== 3'b000) begin
                errors++; $display("FAIL t1_i_quiet: got %b required 000", {i_ack, i_rvalid, i_done});
            end
            if (d_ack) begin
                checks++;
                if (acks > 3 || mem_addr !== exp_addr[acks & 3]) begin
                    errors++; $display("FAIL t1_addr beat %0d: got %h required %h", acks, mem_addr, exp_addr[acks & 3]);
                end
                acks++;
            end
            if (d_rvalid) begin
                checks++;
                if (rvs > 3 || rdata !== (exp_addr[rvs & 3] ^ 16'h5A5A)) begin
                    errors++; $display("FAIL t1_rdata word %0d: got %h required %h", rvs, rdata, exp_addr[rvs & 3] ^ 16'h5A5A);
                end
                rvs++;
            end
            if (d_done) begin
                done_seen = 1'b1;
                checks++;
                if (rvs !== 4 || !d_rvalid) begin
                    errors++; $display("FAIL t1_done_timing: rvalids %0d required 4", rvs);
                end
                d_req = 1'b0;
            end
        end
        d_req = 1'b0;
        checks++;
        if (!done_seen || acks !== 4) begin
            errors++; $display("FAIL t1_complete: done %0d acks %0d required done 1 acks 4", done_seen, acks);
        end
    endtask

    task automatic test_simultaneous();
        int d_done_cyc, i_ack_cyc;
        bit first_ack_seen;
        d_done_cyc = -1; i_ack_cyc = -1; first_ack_seen = 1'b0;
        do_reset();
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
        i_req = 1'b1; i_addr = 16'h0400;
        for (int cyc = 0; cyc < 60 && i_req; cyc++) begin
            @(negedge clk); #1;
            if ((d_ack || i_ack) && !first_ack_seen) begin
                first_ack_seen = 1'b1;
                checks++;
                if (!d_ack) begin
                    errors++; $display("FAIL t2_d_first: d_ack %b i_ack %b required d_ack 1", d_ack, i_ack);
                end
            end
            if (d_done) begin
                d_done_cyc = cyc; d_req = 1'b0;
            end
            if (i_ack && i_ack_cyc < 0) i_ack_cyc = cyc;
            if (i_done) i_req = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (d_done_cyc < 0 || i_ack_cyc < 0 || (i_ack_cyc - d_done_cyc) != 2) begin
            errors++; $display("FAIL t2_i_gap: got %0d cycles required 2", i_ack_cyc - d_done_cyc);
        end
    endtask

    task automatic test_starvation();
        int dones, irv;
        bit i_seen, i_fin;
        dones = 0; irv = 0; i_seen = 1'b0; i_fin = 1'b0;
        do_reset();
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0800;
        i_req = 1'b1; i_addr = 16'h0C00;
        for (int cyc = 0; cyc < 200 && !i_fin; cyc++) begin
            @(negedge clk); #1;
            if (d_done) dones++;
            if (i_ack && !i_seen) begin
                i_seen = 1'b1;
                checks++;
                if (dones !== 2) begin
                    errors++; $display("FAIL t3_d_bursts_before_i: got %0d required 2", dones);
                end
                checks++;
                if (dut.starve_r !== 4'd0) begin
                    errors++; $display("FAIL t3_starve_in_i: got %0d required 0", dut.starve_r);
                end
            end
            if (i_rvalid) irv++;
            if (i_done) begin
                i_fin = 1'b1;
                checks++;
                if (irv !== 4) begin
                    errors++; $display("FAIL t3_i_done: rvalids %0d required 4", irv);
                end
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        checks++;
        if (!i_fin) begin
            errors++; $display("FAIL t3_timeout: i burst done %0d required 1", i_fin);
        end
    endtask

    task automatic test_write_stall();
        logic [15:0] exp_addr [4];
        int acks, stalls;
        bit done_seen, exp_done;
        exp_addr = '{16'h2008, 16'h200A, 16'h200C, 16'h200E};
        acks = 0; stalls = 0; done_seen = 1'b0;
        do_reset();
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h200B; d_wdata = 16'h1000;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            @(negedge clk);
            d_wdata   = 16'h1000 + 16'(acks);
            mem_stall = (acks == 2 && stalls < 3);
            #1;
            if (mem_en) begin
                checks++;
                if (acks > 3 || mem_addr !== exp_addr[acks & 3] || mem_wdata !== (16'h1000 + 16'(acks)) || mem_wr !== 1'b1) begin
                    errors++; $display("FAIL t4_beat %0d: addr %h data %h wr %b required %h %h 1",
                                       acks, mem_addr, mem_wdata, mem_wr, exp_addr[acks & 3], 16'h1000 + 16'(acks));
                end
            end
            if (mem_stall) begin
                stalls++;
                checks++;
                if (d_ack !== 1'b0) begin
                    errors++; $display("FAIL t4_stall_ack: got %b required 0", d_ack);
                end
            end
            exp_done = d_ack && (acks == 3);
            checks++;
            if (d_done !== exp_done) begin
                errors++; $display("FAIL t4_done: got %b required %b at ack %0d", d_done, exp_done, acks);
            end
            if (d_ack) acks++;
            if (d_done) begin
                done_seen = 1'b1; d_req = 1'b0;
            end
        end
        d_req = 1'b0; mem_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (d_ack) acks++;
        end
        checks++;
        if (acks !== 4 || stalls !== 3 || err !== 1'b0) begin
            errors++; $display("FAIL t4_totals: acks %0d stalls %0d err %b required 4 3 0", acks, stalls, err);
        end
    endtask

    task automatic test_reset_mid_burst();
        int acks, irv;
        bit i_fin;
        logic [15:0] exp_addr [4];
        exp_addr = '{16'h0F08, 16'h0F0A, 16'h0F0C, 16'h0F0E};
        acks = 0; irv = 0; i_fin = 1'b0;
        do_reset();
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
        for (int cyc = 0; cyc < 20 && acks < 2; cyc++) begin
            @(negedge clk); #1;
            if (d_ack) acks++;
        end
        @(negedge clk);
        rst = 1'b1; d_req = 1'b0;
        #1;
        checks++;
        if ({mem_en, d_ack, d_rvalid, d_done, i_ack, i_rvalid, i_done, err} !== 8'h00) begin
            errors++; $display("FAIL t5_rst_outputs: got %b required 00000000",
                               {mem_en, d_ack, d_rvalid, d_done, i_ack, i_rvalid, i_done, err});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({d_rvalid, i_rvalid} !== 2'b00) begin
            errors++; $display("FAIL t5_orphan_rv: got %b required 00", {d_rvalid, i_rvalid});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            inj_rv = 1'b1;
            #1;
            checks++;
            if ({d_rvalid, i_rvalid} !== 2'b00) begin
                errors++; $display("FAIL t5_idle_rv: got %b required 00", {d_rvalid, i_rvalid});
            end
        end
        @(negedge clk);
        inj_rv = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL t5_err_idle: got %b required 0", err);
        end
        i_req = 1'b1; i_addr = 16'h0F0A;
        acks = 0;
        for (int cyc = 0; cyc < 40 && !i_fin; cyc++) begin
            @(negedge clk); #1;
            if (i_ack) begin
                checks++;
                if (acks > 3 || mem_addr !== exp_addr[acks & 3]) begin
                    errors++; $display("FAIL t5_i_addr beat %0d: got %h required %h", acks, mem_addr, exp_addr[acks & 3]);
                end
                acks++;
            end
            if (i_rvalid) irv++;
            if (i_done) begin
                i_fin = 1'b1; i_req = 1'b0;
            end
        end
        i_req = 1'b0;
        checks++;
        if (!i_fin || irv !== 4 || err !== 1'b0) begin
            errors++; $display("FAIL t5_i_burst: done %0d rvalids %0d err %b required 1 4 0", i_fin, irv, err);
        end
    endtask

    task automatic test_err_sticky();
        int acks;
        bit injected, done_seen;
        acks = 0; injected = 1'b0; done_seen = 1'b0;
        do_reset();
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0300;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            @(negedge clk);
            inj_rv = (acks == 1 && !injected);
            #1;
            if (inj_rv) begin
                injected = 1'b1;
                checks++;
                if (err !== 1'b0) begin
                    errors++; $display("FAIL t6_err_before: got %b required 0", err);
                end
            end
            if (d_ack) acks++;
            if (d_done) begin
                done_seen = 1'b1; d_req = 1'b0;
            end
        end
        inj_rv = 1'b0; d_req = 1'b0;
        checks++;
        if (err !== 1'b1 || !injected) begin
            errors++; $display("FAIL t6_err_set: got %b required 1", err);
        end
        for (int k = 0; k < 3; k++) @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL t6_err_sticky: got %b required 1", err);
        end
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL t6_err_clear: got %b required 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_write_stall();
        test_reset_mid_burst();
        test_err_sticky();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
